// File: rtl/rv32f_fp_wb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : rv32f_fp_wb_scoreboard
//  Description : FP register-file writeback scoreboard. Tracks pending FP
//                destination registers and stalls issue on RAW/WAW hazards.
//                Buffers FPU completions in a small FIFO and merges them with
//                FP load returns into one registered register-file write.
//                Optional sticky IEEE flag accumulation is enabled by defining
//                the macro RV32F_FFLAGS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32f_fp_wb_scoreboard #(
    parameter int DEPTH    = 4,
    parameter int NUM_REGS = 32
) (
    input  logic                clk,
    input  logic                n_rst,
    // issue side
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [4:0]          issue_rs1,
    input  logic [4:0]          issue_rs2,
    input  logic                issue_uses_rs1,
    input  logic                issue_uses_rs2,
    input  logic                issue_writes_rd,
    input  logic [4:0]          issue_rd,
    // FPU completions
    input  logic                fpu_done,
    output logic                fpu_ready,
    input  logic [4:0]          fpu_rd,
    input  logic [31:0]         fpu_result,
    input  logic [4:0]          fpu_flags,
    // FP load returns
    input  logic                ld_valid,
    input  logic [4:0]          ld_rd,
    input  logic [31:0]         ld_data,
    // register-file write port
    output logic                f_wen,
    output logic [4:0]          f_rd,
    output logic [31:0]         f_wdata,
    // status
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [4:0]          fflags,
    input  logic                fflags_clr
);

    localparam int              c_PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              c_CNT_W  = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_REGS-1:0] r_busy;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_wen;
    logic [4:0]          r_rd;
    logic [31:0]         r_wdata;

    logic [4:0]          r_fifo_rd   [DEPTH];
    logic [31:0]         r_fifo_data [DEPTH];

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                w_issue_ready;
    logic                w_issue_fire;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_bypass;
    logic                w_fifo_wr;
    logic [NUM_REGS-1:0] w_busy_nxt;

    // Hazard check looks only at the registered busy bits; a result being
    // written this cycle still stalls its consumers for one more cycle.
    assign w_issue_ready = !(issue_uses_rs1  && r_busy[issue_rs1]) &&
                           !(issue_uses_rs2  && r_busy[issue_rs2]) &&
                           !(issue_writes_rd && r_busy[issue_rd]);
    assign w_issue_fire  = issue_valid && w_issue_ready;

    assign w_full    = (r_count == c_FULL);
    assign w_empty   = (r_count == '0);
    assign w_push    = fpu_done && !w_full;
    // Loads own the write port whenever present; the FIFO simply holds.
    assign w_pop     = !ld_valid && !w_empty;
    // Empty FIFO and idle port: the completion skips storage entirely.
    assign w_bypass  = !ld_valid && w_empty && w_push;
    assign w_fifo_wr = w_push && !w_bypass;

    // Next busy vector: writeback clears first so a same-index issue set wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_wen) begin
            w_busy_nxt[r_rd] = 1'b0;
        end
        if (w_issue_fire && issue_writes_rd) begin
            w_busy_nxt[issue_rd] = 1'b1;
        end
    end

    // Pending-write bit register.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_fifo_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_fifo_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until the count covers them.
    always_ff @(posedge clk) begin
        if (w_fifo_wr) begin
            r_fifo_rd[r_wr_ptr]   <= fpu_rd;
            r_fifo_data[r_wr_ptr] <= fpu_result;
        end
    end

    // Writeback output register: load, else FIFO head, else bypass.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_wen   <= 1'b0;
            r_rd    <= '0;
            r_wdata <= '0;
        end else if (ld_valid) begin
            r_wen   <= 1'b1;
            r_rd    <= ld_rd;
            r_wdata <= ld_data;
        end else if (w_pop) begin
            r_wen   <= 1'b1;
            r_rd    <= r_fifo_rd[r_rd_ptr];
            r_wdata <= r_fifo_data[r_rd_ptr];
        end else if (w_bypass) begin
            r_wen   <= 1'b1;
            r_rd    <= fpu_rd;
            r_wdata <= fpu_result;
        end else begin
            r_wen   <= 1'b0;
        end
    end

`ifdef RV32F_FFLAGS_EN
    logic [4:0] r_fifo_flags [DEPTH];
    logic [4:0] r_fflags;
    logic [4:0] w_wb_flags;
    logic       w_fpu_wb;

    assign w_fpu_wb   = w_pop || w_bypass;
    assign w_wb_flags = w_pop ? r_fifo_flags[r_rd_ptr] : fpu_flags;

    // Flag storage travels alongside each queued result.
    always_ff @(posedge clk) begin
        if (w_fifo_wr) begin
            r_fifo_flags[r_wr_ptr] <= fpu_flags;
        end
    end

    // Sticky flags: OR in on FPU writeback; a CSR clear takes priority.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_fflags <= '0;
        end else if (fflags_clr) begin
            r_fflags <= '0;
        end else if (w_fpu_wb) begin
            r_fflags <= r_fflags | w_wb_flags;
        end
    end

    assign fflags = r_fflags;
`else
    logic w_unused_flags;
    assign w_unused_flags = ^{fpu_flags, fflags_clr};
    assign fflags         = 5'd0;
`endif

    assign issue_ready = w_issue_ready;
    assign fpu_ready   = !w_full;
    assign f_wen       = r_wen;
    assign f_rd        = r_rd;
    assign f_wdata     = r_wdata;
    assign busy_vec    = r_busy;

endmodule
`default_nettype wire
